// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the CPU: opcodes, ALU operation codes and
// sequencer state encodings. The DataPath ALU imports the same ALU codes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OPC_ADD = 5'b00011;
  localparam logic [4:0] OPC_SUB = 5'b00100;
  localparam logic [4:0] OPC_AND = 5'b00101;
  localparam logic [4:0] OPC_OR  = 5'b00110;
  localparam logic [4:0] OPC_SHR = 5'b00111;
  localparam logic [4:0] OPC_SHL = 5'b01000;
  localparam logic [4:0] OPC_NOT = 5'b01101;
  localparam logic [4:0] OPC_NEG = 5'b01110;
  localparam logic [4:0] OPC_MUL = 5'b01111;
  localparam logic [4:0] OPC_DIV = 5'b10000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_NEG = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T1W, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } ctrl_state_t;

  function automatic logic opcode_legal(input logic [4:0] opcode);
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL,
      OPC_NOT, OPC_NEG, OPC_MUL, OPC_DIV: opcode_legal = 1'b1;
      default:                            opcode_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] opcode);
    case (opcode)
      OPC_ADD: alu_code = ALU_ADD;
      OPC_SUB: alu_code = ALU_SUB;
      OPC_AND: alu_code = ALU_AND;
      OPC_OR:  alu_code = ALU_OR;
      OPC_SHR: alu_code = ALU_SHR;
      OPC_SHL: alu_code = ALU_SHL;
      OPC_NEG: alu_code = ALU_NEG;
      OPC_NOT: alu_code = ALU_NOT;
      OPC_MUL: alu_code = ALU_MUL;
      OPC_DIV: alu_code = ALU_DIV;
      default: alu_code = 4'b0000;
    endcase
  endfunction

  // Unary ops take their single operand from Rb; long ops write a HI/LO pair
  function automatic logic is_unary(input logic [4:0] opcode);
    is_unary = (opcode == OPC_NEG) || (opcode == OPC_NOT);
  endfunction

  function automatic logic is_long(input logic [4:0] opcode);
    is_long = (opcode == OPC_MUL) || (opcode == OPC_DIV);
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Turns a 4-bit register field plus an enable into a one-hot select for R0..R15.
module reg_sel_decoder (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  assign onehot = en ? (16'h0001 << sel) : 16'h0000;

endmodule

// File: rtl/reg_op_sequencer.sv
// Moore control sequencer for register-register instructions: fetch, decode,
// execute and write-back strobes decoded from the current state and IR fields.
module reg_op_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_rdy,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [3:0]  operation,
  output logic        busy,
  output logic        done,
  output logic        err
);

  ctrl_state_t state;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;
  logic [3:0] rout_sel, rin_sel;
  logic       rout_en, rin_en;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= start ? ST_T0 : ST_IDLE;
        ST_T0:   state <= ST_T1;
        ST_T1:   state <= mem_rdy ? ST_T2 : ST_T1W;
        ST_T1W:  state <= mem_rdy ? ST_T2 : ST_T1W;
        ST_T2:   state <= ST_T3;
        ST_T3:   state <= opcode_legal(opcode) ? ST_T4 : ST_HALT;
        ST_T4:   state <= ST_T5;
        ST_T5:   state <= is_long(opcode) ? ST_T6 : ST_IDLE;
        ST_T6:   state <= ST_IDLE;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // IR fields only reach the outputs from T3 onward, after IRin has loaded it
  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Zin_low   = 1'b0;
    Zin_high  = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    operation = 4'b0000;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    rout_en   = 1'b0;
    rout_sel  = rb;
    rin_en    = 1'b0;
    rin_sel   = ra;
    case (state)
      ST_IDLE: ;
      ST_T0: begin
        busy    = 1'b1;
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
      end
      ST_T1: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T1W: begin
        busy  = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        busy = 1'b1;
        if (opcode_legal(opcode)) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end
      end
      ST_T4: begin
        busy      = 1'b1;
        operation = alu_code(opcode);
        Zin_low   = 1'b1;
        Zin_high  = 1'b1;
        rout_en   = 1'b1;
        rout_sel  = is_unary(opcode) ? rb : rc;
      end
      ST_T5: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        if (is_long(opcode)) begin
          LOin = 1'b1;
        end else begin
          rin_en = 1'b1;
          done   = 1'b1;
        end
      end
      ST_T6: begin
        busy     = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      ST_HALT: err = 1'b1;
      default: ;
    endcase
  end

  reg_sel_decoder u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_sel_decoder u_rin_dec (
    .sel    (rin_sel),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench: per-cycle expected strobe vectors built from the
// instruction-level timing rules, compared against the sequencer every cycle.
module tb_reg_op_sequencer;

  logic        Clock = 1'b0;
  logic        clear, start, mem_rdy;
  logic [31:0] IR;
  logic        PCout, Zlowout, Zhighout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read;
  logic [15:0] Rout, Rin;
  logic [3:0]  operation;
  logic        busy, done, err;

  typedef struct packed {
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read;
    logic [15:0] Rout, Rin;
    logic [3:0]  operation;
    logic        busy, done, err;
  } obs_t;

  obs_t obs;
  int   checks = 0;
  int   errors = 0;

  obs_t        exp_q[$];
  logic [31:0] ir_q[$];
  bit          rdy_q[$];
  bit          st_q[$];

  logic [4:0] legal_ops [10] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01110, 5'b01101, 5'b01111, 5'b10000};

  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, HIin,
                LOin, Zin_low, Zin_high, IncPC, Read, Rout, Rin, operation, busy, done, err};

  reg_op_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Zin_low(Zin_low), .Zin_high(Zin_high),
    .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin), .operation(operation),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clock = ~Clock;

  // Bus exclusivity holds in every cycle regardless of scenario
  always @(negedge Clock) begin
    #2;
    checks++;
    if (!$onehot0(Rout) || !$onehot0(Rin) ||
        $countones({PCout, Zlowout, Zhighout, MDRout, |Rout}) > 1) begin
      errors++;
      $display("[TB] FAIL bus_exclusive t=%0t: Rout=%h Rin=%h drivers=%b, required one-hot0 and <=1 driver",
               $time, Rout, Rin, {PCout, Zlowout, Zhighout, MDRout, |Rout});
    end
  end

  function automatic void ref_decode(input logic [4:0] opc, output bit legal,
                                     output logic [3:0] alu, output bit unary, output bit long_op);
    legal = 1; unary = 0; long_op = 0; alu = 4'h0;
    case (opc)
      5'b00011: alu = 4'h0;
      5'b00100: alu = 4'h1;
      5'b00101: alu = 4'h2;
      5'b00110: alu = 4'h3;
      5'b00111: alu = 4'h4;
      5'b01000: alu = 4'h5;
      5'b01110: begin alu = 4'h6; unary = 1; end
      5'b01101: begin alu = 4'h7; unary = 1; end
      5'b01111: begin alu = 4'h8; long_op = 1; end
      5'b10000: begin alu = 4'h9; long_op = 1; end
      default:  legal = 0;
    endcase
  endfunction

  task automatic push_cycle(input obs_t e, input bit st, input bit rdy, input logic [31:0] irv);
    exp_q.push_back(e);
    st_q.push_back(st);
    rdy_q.push_back(rdy);
    ir_q.push_back(irv);
  endtask

  // Whole-instruction timeline: IDLE+start, fetch with waits, decode, execute, write-back
  task automatic build_expected(input logic [31:0] ir, input int waits, input bit noise);
    obs_t e;
    bit legal, unary, long_op;
    logic [3:0] alu;
    int ra, rb, rc;
    exp_q.delete(); st_q.delete(); rdy_q.delete(); ir_q.delete();
    ref_decode(ir[31:27], legal, alu, unary, long_op);
    ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    e = '0;
    push_cycle(e, 1, 1'($urandom), noise ? $urandom : ir);
    e = '0; e.busy = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin_low = 1;
    push_cycle(e, 1'($urandom), 1'($urandom), noise ? $urandom : ir);
    e = '0; e.busy = 1; e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1;
    push_cycle(e, 1'($urandom), waits == 0, noise ? $urandom : ir);
    for (int j = 0; j < waits; j++) begin
      e = '0; e.busy = 1; e.Read = 1; e.MDRin = 1;
      push_cycle(e, 1'($urandom), j == waits - 1, noise ? $urandom : ir);
    end
    e = '0; e.busy = 1; e.MDRout = 1; e.IRin = 1;
    push_cycle(e, 1'($urandom), 1'($urandom), noise ? $urandom : ir);
    e = '0; e.busy = 1;
    if (legal) begin e.Rout = 16'h0001 << rb; e.Yin = 1; end
    push_cycle(e, 1'($urandom), 1'($urandom), ir);
    if (!legal) begin
      for (int k = 0; k < 4; k++) begin
        e = '0; e.err = 1;
        push_cycle(e, k[0], 1'($urandom), $urandom);
      end
      return;
    end
    e = '0; e.busy = 1; e.operation = alu; e.Zin_low = 1; e.Zin_high = 1;
    e.Rout = 16'h0001 << (unary ? rb : rc);
    push_cycle(e, 1'($urandom), 1'($urandom), ir);
    e = '0; e.busy = 1; e.Zlowout = 1;
    if (long_op) e.LOin = 1;
    else begin e.Rin = 16'h0001 << ra; e.done = 1; end
    push_cycle(e, 1'($urandom), 1'($urandom), ir);
    if (long_op) begin
      e = '0; e.busy = 1; e.Zhighout = 1; e.HIin = 1; e.done = 1;
      push_cycle(e, 1'($urandom), 1'($urandom), ir);
    end
    e = '0;
    push_cycle(e, 0, 1'($urandom), ir);
  endtask

  task automatic run_expected(input string name, input int abort_idx);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      start = st_q[i]; mem_rdy = rdy_q[i]; IR = ir_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got %h required %h", name, i, obs, exp_q[i]);
      end
      if (i == abort_idx) begin
        #1 clear = 1'b1;
        #1;
        checks++;
        if (obs !== obs_t'(0)) begin
          errors++;
          $display("[TB] FAIL %s async_clear: got %h required 0", name, obs);
        end
        @(negedge Clock);
        clear = 1'b0; start = 1'b0;
        return;
      end
    end
  endtask

  task automatic pulse_clear(input string name);
    @(negedge Clock);
    #2 clear = 1'b1;
    #1;
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL %s clear_outputs: got %h required 0", name, obs);
    end
    @(negedge Clock);
    clear = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    clear = 1'b1; start = 1'b1; mem_rdy = 1'b1; IR = 32'h2022_8000;
    repeat (2) @(negedge Clock);
    #1;
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_held: got %h required 0", obs);
    end
    clear = 1'b0; start = 1'b1;
    @(negedge Clock);
    #1;
    e = '0; e.busy = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin_low = 1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("[TB] FAIL first_edge_after_clear: got %h required %h", obs, e);
    end
    start = 1'b0;
    pulse_clear("reset_reclear");
  endtask

  task automatic test_sub();
    build_expected(32'h2022_8000, 0, 0);
    run_expected("sub_directed", -1);
  endtask

  task automatic test_mul();
    build_expected(32'h7833_8000, 0, 0);
    run_expected("mul_directed", -1);
  endtask

  task automatic test_wait_states();
    build_expected(32'h2022_8000, 3, 1);
    run_expected("sub_wait3", -1);
  endtask

  task automatic test_illegal();
    build_expected(32'hF800_0000, 0, 0);
    run_expected("illegal_halt", -1);
    pulse_clear("halt_clear");
  endtask

  task automatic test_clear_mid();
    build_expected(32'h2022_8000, 0, 0);
    run_expected("clear_in_t4", 5);
    build_expected(32'h2022_8000, 1, 0);
    run_expected("refetch_after_clear", -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ir;
    bit legal, unary, long_op;
    logic [3:0] alu;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) != 0) ir = {legal_ops[$urandom_range(0, 9)], 27'($urandom)};
      else ir = $urandom;
      ref_decode(ir[31:27], legal, alu, unary, long_op);
      build_expected(ir, $urandom_range(0, 3), 1);
      run_expected($sformatf("random_%0d_ir%h", n, ir), -1);
      if (!legal) pulse_clear("random_halt_clear");
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_mul();
    test_wait_states();
    test_illegal();
    test_clear_mid();
    test_back_to_back();
    @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 SHALL have port Clock  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have port clear  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  in  1  request to fetch/execute one instruction, sampled only in IDLE.
REQ-004 SHALL have port mem_rdy  in  1  memory read data valid on Mdatain this cycle.
REQ-005 SHALL have port IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-006 SHALL have ports PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive strobes.
REQ-007 SHALL have ports MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read  out  1 each  load/control strobes.
REQ-008 SHALL have port Rout  out  16  one-hot general register bus-drive select (R0..R15).
REQ-009 SHALL have port Rin  out  16  one-hot general register load select.
REQ-010 SHALL have port operation  out  4  ALU operation code.
REQ-011 SHALL have ports busy, done, err  out  1 each  status.

Function
REQ-012 SHALL be a Moore FSM: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT; all strobes decoded from state (plus IR fields) only.
REQ-013 IDLE: all strobes 0; start=1 -> T0 next edge, else stay.
REQ-014 T0: PCout, MARin, IncPC, Zin_low = 1 -> T1.
REQ-015 T1: Zlowout, PCin, Read, MDRin = 1; mem_rdy=1 -> T2, else -> T1W.
REQ-016 T1W: Read, MDRin = 1, PCin = 0; stay until mem_rdy=1 -> T2 (no timeout).
REQ-017 T2: MDRout, IRin = 1 -> T3.
REQ-018 T3: opcode decoded; illegal -> HALT with no strobes this cycle; legal: Rout[Rb], Yin = 1 -> T4.
REQ-019 Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, NEG 01110, NOT 01101, MUL 01111, DIV 10000; all others illegal.
REQ-020 T4: operation = mapped code, Zin_low, Zin_high = 1; Rout[Rc] = 1 for binary ops, Rout[Rb] = 1 for NEG/NOT -> T5.
REQ-021 T5: Zlowout = 1; Rin[Ra] = 1 for non-MUL/DIV, LOin = 1 for MUL/DIV; non-MUL/DIV -> IDLE, MUL/DIV -> T6.
REQ-022 T6 (MUL/DIV only): Zhighout, HIin = 1 -> IDLE.
REQ-023 done = 1 exactly one cycle: in T5 for non-MUL/DIV, in T6 for MUL/DIV.
REQ-024 busy = 1 in every state except IDLE and HALT.
REQ-025 HALT: err = 1, all strobes 0, stay until clear; start ignored.
REQ-026 At most one bit of Rout and of Rin SHALL be 1 in any cycle; never more than one bus driver active per cycle.
REQ-027 IR SHALL be sampled combinationally in T3..T6 only; IR changes in T0..T2 have no effect.
REQ-028 Ra = Rb = Rc permitted; no special handling.
REQ-029 ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SHR 0100, SHL 0101, NEG 0110, NOT 0111, MUL 1000, DIV 1001.

Reset
REQ-030 clear=1 SHALL force state IDLE immediately, all outputs 0 (operation = 0000), including mid-instruction and in HALT.
REQ-031 First rising edge after clear falls SHALL evaluate IDLE rules.

Structure
REQ-032 Opcode constants, ALU operation codes and state encodings SHALL live in shared package cpu_ctrl_pkg, also used by DataPath ALU.
REQ-033 One sub-module SHALL be natural: reg_sel_decoder (4-bit field + enable -> 16-bit one-hot), instantiated twice for Rout and Rin.

Verification
REQ-034 IR=0x20228000 (SUB R0,R4,R5), mem_rdy=1: states T0..T5 in 6 cycles; T3 Rout=0x0010, T4 Rout=0x0020 operation=0001, T5 Rin=0x0001 done=1.
REQ-035 IR=0x78338000 (MUL R6,R7): T5 LOin=1 Rin=0, T6 Zhighout=HIin=1 done=1; 7 cycles total.
REQ-036 SUB with mem_rdy low 3 cycles: T1 once (PCin one cycle), T1W 3 cycles with Read=MDRin=1, PCin=0.
REQ-037 IR=0xF8000000: T3 -> HALT, err=1, all strobes 0; start pulses ignored; clear -> IDLE, err=0.
REQ-038 clear asserted during T4: outputs 0 same cycle without clock edge; next start runs full fetch from T0.
REQ-039 Every cycle assertion: $onehot0(Rout), $onehot0(Rin), at most one of PCout/Zlowout/Zhighout/MDRout/|Rout.
